frame_max: RTL and testbench
============================

FRAME_MAX -- requirements
Module: frame_max

Interface
REQ-001 SHALL have parameter WIDTH, default 10, giving the data and timestamp width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 4, giving the width of the beat counter.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-007 SHALL have port in_data, input, WIDTH bits: value to reduce.
REQ-008 SHALL have port in_last, input, 1 bit: marks the final beat of a frame; qualified by in_valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block can accept a beat this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: frame result available.
REQ-011 SHALL have port out_data, output, WIDTH bits: maximum of the frame.
REQ-012 SHALL have port out_count, output, CNT_WIDTH bits: number of beats in the frame, saturating.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the result.

Function
REQ-014 SHALL transfer an input beat only in a cycle where in_valid=1 and in_ready=1.
REQ-015 SHALL transfer the output only in a cycle where out_valid=1 and out_ready=1.
REQ-016 SHALL implement a three-state FSM: EMPTY, ACCUM, DONE.
REQ-017 SHALL drive in_ready=1 in EMPTY and ACCUM and in_ready=0 in DONE, as a registered-state decode with no combinational path from out_ready.
REQ-018 SHALL drive out_valid=1 only in DONE.
REQ-019 SHALL hold out_data and out_count stable while in DONE.
REQ-020 On an accepted beat in EMPTY, SHALL set acc=in_data and cnt=1, then go to DONE if in_last=1, else to ACCUM.
REQ-021 On an accepted beat in ACCUM, SHALL set acc=sel(acc, in_data) and cnt=cnt+1, saturating at 2^CNT_WIDTH-1, then go to DONE if in_last=1, else stay in ACCUM.
REQ-022 SHALL compute sel(a,b) wrap-aware: diff=(b-a) mod 2^WIDTH; result is a if diff[WIDTH-1]=1, else b.
REQ-023 SHALL select the new value on equal inputs (diff=0); the result value is identical either way.
REQ-024 With no accepted beat in EMPTY or ACCUM, SHALL leave state, acc and cnt unchanged.
REQ-025 In DONE with out_ready=1, SHALL go to EMPTY next cycle; with out_ready=0, SHALL remain in DONE.
REQ-026 SHALL assert out_valid in the cycle after the in_last beat is accepted (latency 1).
REQ-027 Throughput: a frame of N beats SHALL occupy N+1 cycles minimum, counting the result handshake cycle.
REQ-028 SHALL drive out_data=acc and out_count=cnt in all states; these are meaningful only when out_valid=1.
REQ-029 SHALL ignore in_data and in_last when in_valid=0.

Reset
REQ-030 On reset=1 at a clock edge, SHALL go to EMPTY with acc=0 and cnt=0, so out_valid=0, in_ready=1, out_data=0 and out_count=0 from the next cycle.
REQ-031 Reset SHALL take priority over any simultaneous handshake; a partial frame or unconsumed result is discarded.
REQ-032 SHALL not accept a beat in a cycle where reset=1.

Verification
REQ-033 Frame 3,7,5 (last on 5), out_ready=1 -> out_valid one cycle after the 5 beat, with out_data=7 and out_count=3; back in EMPTY the following cycle.
REQ-034 Wrap: frame 1000,5 -> out_data=5, since diff=29 and the MSB is clear; frame 5,1000 -> out_data=5, since diff=995 and the MSB is set.
REQ-035 Single-beat frame 42 with in_last=1 -> out_data=42, out_count=1; hold out_ready=0 for 4 cycles -> out_valid stays 1, in_ready stays 0, data stable; then out_ready=1 -> EMPTY.
REQ-036 20-beat frame of values 0..19 with CNT_WIDTH=4 -> out_data=19, out_count=15 (saturated).
REQ-037 Reset asserted after 2 beats of a frame (9,8) -> no out_valid; a new frame 4 (last) -> out_data=4, out_count=1.
REQ-038 Gaps: in_valid toggling 1,0,0,1 on frame 2,6 -> out_data=6, out_count=2; idle cycles leave acc unchanged.

Source files
------------

// File: rtl/frame_max.sv
// Per-frame maximum reducer with a wrap-aware compare and a saturating beat count.
// The frame result is held in DONE until the downstream side takes it.
module frame_max #(
  parameter int WIDTH     = 10,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {EMPTY, ACCUM, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     acc_reg, acc_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     sel_val;
  logic                 beat;

  // Modular distance decides "newer is larger"; a set MSB means in_data lies behind acc.
  assign diff    = in_data - acc_reg;
  assign sel_val = diff[WIDTH-1] ? acc_reg : in_data;

  assign in_ready  = (state_reg != DONE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = acc_reg;
  assign out_count = cnt_reg;
  assign beat      = in_valid & in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= EMPTY;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      EMPTY: begin
        if (beat) begin
          acc_next   = in_data;
          cnt_next   = CNT_ONE;
          state_next = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_next   = sel_val;
          cnt_next   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
          state_next = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_frame_max.sv
// Directed bench for frame_max: reset, wrap-aware max, backpressure, saturation, gaps.
module tb_frame_max;

  localparam int WIDTH     = 10;
  localparam int CNT_WIDTH = 4;

  logic                 clock;
  logic                 reset;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_ready;

  int total;
  int bad;

  frame_max #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Present one beat at a falling edge; returns at the falling edge after it is taken.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    chk("in_ready_on_beat", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int d, input int c);
    $display("result %s: out_valid=%0d out_data=%0d out_count=%0d", tag, out_valid, out_data, out_count);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    reset = 1'b0;

    // Frame 3,7,5
    send(10'd3, 1'b0);
    send(10'd7, 1'b0);
    send(10'd5, 1'b1);
    chk_result("f375", 7, 3);
    step();
    chk("f375_empty_valid", 32'(out_valid), 32'd0);
    chk("f375_empty_ready", 32'(in_ready), 32'd1);

    // Wrap-aware compare both directions
    send(10'd1000, 1'b0);
    send(10'd5, 1'b1);
    chk_result("wrap_1000_5", 5, 2);
    step();
    send(10'd5, 1'b0);
    send(10'd1000, 1'b1);
    chk_result("wrap_5_1000", 5, 2);
    step();

    // Single beat with downstream stall; offered beats during DONE must be refused
    out_ready = 1'b0;
    send(10'd42, 1'b1);
    chk_result("single42", 42, 1);
    in_valid = 1'b1;
    in_data  = 10'd99;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_data", 32'(out_data), 32'd42);
      chk("hold_count", 32'(out_count), 32'd1);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    chk("single42_empty", 32'(out_valid), 32'd0);
    chk("single42_ready", 32'(in_ready), 32'd1);

    // 20 beats 0..19: count saturates at 15
    for (int i = 0; i < 20; i++) begin
      send(10'(i), (i == 19));
    end
    chk_result("sat20", 19, 15);
    step();

    // Reset mid-frame, with a beat offered during the reset cycle
    send(10'd9, 1'b0);
    send(10'd8, 1'b0);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 10'd77;
    in_last  = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_count", 32'(out_count), 32'd0);
    step();
    chk("midrst_valid2", 32'(out_valid), 32'd0);
    send(10'd4, 1'b1);
    chk_result("after_rst", 4, 1);
    step();

    // Reset discards an unconsumed result
    out_ready = 1'b0;
    send(10'd11, 1'b1);
    chk_result("pending11", 11, 1);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    chk("pendrst_valid", 32'(out_valid), 32'd0);
    chk("pendrst_ready", 32'(in_ready), 32'd1);

    // Gaps: idle cycles carry junk that must be ignored
    send(10'd2, 1'b0);
    in_data = 10'd500;
    in_last = 1'b1;
    step();
    step();
    chk("gap_valid", 32'(out_valid), 32'd0);
    chk("gap_acc", 32'(out_data), 32'd2);
    chk("gap_count", 32'(out_count), 32'd1);
    send(10'd6, 1'b1);
    chk_result("gap26", 6, 2);
    step();
    chk("gap_empty", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
